// File: rtl/m4_frame_capture_pkg.sv
// Shared types and default geometry for the Model 4 frame capture block.
package m4_capture_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        WAIT_VS,
        NORMAL
    } cap_state_t;

    typedef logic cap_mode_t;

    localparam cap_mode_t MODE_64COL = 1'b0;
    localparam cap_mode_t MODE_80COL = 1'b1;

    // Default frame buffer geometry: 800 pixels per row, 240 rows.
    localparam int FB_STRIDE_DEF = 800;
    localparam int FB_DEPTH_DEF  = 192000;

endpackage

// File: rtl/m4_frame_capture_if.sv
// Capture-side bundle: raw TRS-80 video timing in, frame buffer write port
// and status out. The master is the video source / buffer side, the slave
// is the capture block.
interface m4_frame_capture_if #(
    parameter int ADDR_W = 18
);
    logic              hsync;
    logic              vsync;
    logic              video;
    logic [ADDR_W-1:0] waddr;
    logic              pixel_state;
    logic              wren;
    logic              mode;
    logic              clearing;

    modport master (
        output hsync, vsync, video,
        input  waddr, pixel_state, wren, mode, clearing
    );

    modport slave (
        input  hsync, vsync, video,
        output waddr, pixel_state, wren, mode, clearing
    );
endinterface

// File: rtl/m4_frame_capture_sync_2ff.sv
// Single-bit two-flop synchroniser with a selectable reset level so idle-high
// syncs do not produce a spurious edge when reset is released.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/m4_frame_capture.sv
// Model 4 video input monitor: samples hsync/vsync/video on dotclk and writes
// one pixel per dot into the frame buffer. Detects 64/80-column mode from the
// line length, clears the buffer on boot and on every mode change.
// Optional: define CAPTURE_DEBUG_EN to add dbg_line_len / dbg_frame_cnt ports.
module m4_frame_capture
    import m4_capture_pkg::*;
#(
    parameter int ADDR_W       = 18,
    parameter int CNT_W        = 10,
    parameter int FB_STRIDE    = FB_STRIDE_DEF,
    parameter int FB_DEPTH     = FB_DEPTH_DEF,
    parameter int GLITCH_MIN   = 320,
    parameter int MODE_THRESH  = 720,
    parameter int STABLE_LINES = 4,
    parameter int X_OFF0       = 16,
    parameter int Y_OFF0       = 0,
    parameter int X_OFF1       = -71,
    parameter int Y_OFF1       = 8
) (
    input  logic                 dotclk,
    input  logic                 reset,
    m4_frame_capture_if.slave    bus
`ifdef CAPTURE_DEBUG_EN
    ,
    output logic [CNT_W-1:0]     dbg_line_len,
    output logic [CNT_W-1:0]     dbg_frame_cnt
`endif
);
    // Address arithmetic is done signed, wide enough that no row/offset
    // combination can wrap before the range check.
    localparam int AW    = ADDR_W + CNT_W + 2;
    localparam int STB_W = $clog2(STABLE_LINES + 1);

    localparam logic signed [AW-1:0] STRIDE_S = AW'(FB_STRIDE);
    localparam logic signed [AW-1:0] DEPTH_S  = AW'(FB_DEPTH);
    localparam logic [ADDR_W-1:0]    CLR_LAST = ADDR_W'(FB_DEPTH - 1);

    logic hs_s, vs_s, vid_s, hs_d;

    cap_state_t        state;
    cap_mode_t         mode_r;
    logic [ADDR_W-1:0] clr_ctr;
    logic [ADDR_W-1:0] waddr_r;
    logic [CNT_W-1:0]  x, y;
    logic [STB_W-1:0]  stable_cnt;
    logic              pixel_r, wren_r, clearing_r;

    sync_2ff #(.RST_VAL(1'b1)) u_sync_hs  (.clk(dotclk), .reset(reset), .d(bus.hsync), .q(hs_s));
    sync_2ff #(.RST_VAL(1'b1)) u_sync_vs  (.clk(dotclk), .reset(reset), .d(bus.vsync), .q(vs_s));
    sync_2ff #(.RST_VAL(1'b0)) u_sync_vid (.clk(dotclk), .reset(reset), .d(bus.video), .q(vid_s));

    // Delayed synced hsync for falling-edge detection.
    always_ff @(posedge dotclk) begin
        if (reset) hs_d <= 1'b1;
        else       hs_d <= hs_s;
    end

    logic line_end, vblank;
    assign line_end = hs_d & ~hs_s;
    assign vblank   = ~vs_s;

    logic [CNT_W-1:0] x_inc, y_inc;
    assign x_inc = (x == '1) ? x : x + 1'b1;
    assign y_inc = (y == '1) ? y : y + 1'b1;

    // Placement offsets follow the currently detected mode.
    int x_off, y_off;
    assign x_off = (mode_r == MODE_80COL) ? X_OFF1 : X_OFF0;
    assign y_off = (mode_r == MODE_80COL) ? Y_OFF1 : Y_OFF0;

    logic signed [AW-1:0] xs, ys, xo, yo, addr;
    logic                 in_range;
    assign xs       = $signed({{(AW-CNT_W){1'b0}}, x});
    assign ys       = $signed({{(AW-CNT_W){1'b0}}, y});
    assign xo       = AW'(x_off);
    assign yo       = AW'(y_off);
    assign addr     = STRIDE_S * (ys - yo) + xs + xo;
    assign in_range = !addr[AW-1] && (addr < DEPTH_S);

    // Line length (x at line end) classification for mode detection.
    logic      glitch;
    cap_mode_t cand;
    assign glitch = (x <= CNT_W'(GLITCH_MIN));
    assign cand   = cap_mode_t'(x > CNT_W'(MODE_THRESH));

    // Main FSM: buffer clear, vsync alignment, pixel capture and mode filter.
    always_ff @(posedge dotclk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_ctr    <= '0;
            x          <= '0;
            y          <= '0;
            stable_cnt <= '0;
            mode_r     <= MODE_64COL;
            waddr_r    <= '0;
            pixel_r    <= 1'b0;
            wren_r     <= 1'b0;
            clearing_r <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    wren_r  <= 1'b1;
                    pixel_r <= 1'b0;
                    waddr_r <= clr_ctr;
                    if (clr_ctr == CLR_LAST) begin
                        clr_ctr    <= '0;
                        clearing_r <= 1'b0;
                        state      <= WAIT_VS;
                    end else begin
                        clr_ctr <= clr_ctr + 1'b1;
                    end
                end
                WAIT_VS: begin
                    wren_r <= 1'b0;
                    if (vblank) begin
                        x     <= '0;
                        y     <= '0;
                        state <= NORMAL;
                    end
                end
                NORMAL: begin
                    if (vblank) begin
                        x      <= '0;
                        y      <= '0;
                        wren_r <= 1'b0;
                    end else if (line_end) begin
                        wren_r <= 1'b0;
                        x      <= '0;
                        y      <= y_inc;
                        if (!glitch) begin
                            if (cand == mode_r) begin
                                stable_cnt <= '0;
                            end else if (stable_cnt == STB_W'(STABLE_LINES - 1)) begin
                                mode_r     <= cand;
                                stable_cnt <= '0;
                                clearing_r <= 1'b1;
                                state      <= CLEAR;
                            end else begin
                                stable_cnt <= stable_cnt + 1'b1;
                            end
                        end
                    end else begin
                        wren_r  <= in_range;
                        pixel_r <= vid_s;
                        x       <= x_inc;
                        if (in_range) waddr_r <= addr[ADDR_W-1:0];
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.waddr       = waddr_r;
    assign bus.pixel_state = pixel_r;
    assign bus.wren        = wren_r;
    assign bus.mode        = mode_r;
    assign bus.clearing    = clearing_r;

`ifdef CAPTURE_DEBUG_EN
    logic vs_d;

    // LED-bar debug: last non-glitch line length and vsync fall count.
    always_ff @(posedge dotclk) begin
        if (reset) begin
            vs_d          <= 1'b1;
            dbg_line_len  <= '0;
            dbg_frame_cnt <= '0;
        end else begin
            vs_d <= vs_s;
            if (vs_d && !vs_s) dbg_frame_cnt <= dbg_frame_cnt + 1'b1;
            if (state == NORMAL && !vblank && line_end && !glitch) dbg_line_len <= x;
        end
    end
`endif

endmodule

// File: tb/tb_m4_frame_capture.sv
// Directed bench for m4_frame_capture with a reduced frame buffer depth so
// every clear sequence stays short.
module tb_m4_frame_capture;
    localparam int DEPTH = 4000;

    logic dotclk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    m4_frame_capture_if #(.ADDR_W(18)) bus ();

`ifdef CAPTURE_DEBUG_EN
    logic [9:0] dbg_line_len, dbg_frame_cnt;
`endif

    m4_frame_capture #(.FB_DEPTH(DEPTH)) dut (
        .dotclk (dotclk),
        .reset  (reset),
        .bus    (bus)
`ifdef CAPTURE_DEBUG_EN
        ,
        .dbg_line_len  (dbg_line_len),
        .dbg_frame_cnt (dbg_frame_cnt)
`endif
    );

    always #5 dotclk = ~dotclk;

    task automatic tick();
        @(posedge dotclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full clear: DEPTH consecutive zero writes at 0..DEPTH-1, then idle.
    task automatic clear_check(input string tag);
        int          bad   = 0;
        int          first = -1;
        logic [31:0] fa    = 0;
        logic        clr0  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == 0) clr0 = bus.clearing;
            if (!(bus.wren === 1'b1 && bus.waddr === 18'(i) && bus.pixel_state === 1'b0)) begin
                if (first < 0) begin
                    first = i;
                    fa    = 32'(bus.waddr);
                end
                bad++;
            end
        end
        check({tag, "_bad_writes"}, 32'(bad), 32'd0);
        if (bad > 0) $display("  %s: first bad index %0d waddr %0d", tag, first, fa);
        check({tag, "_clearing_first"}, 32'(clr0), 32'd1);
        tick();
        check({tag, "_wren_after"}, 32'(bus.wren), 32'd0);
        check({tag, "_clearing_after"}, 32'(bus.clearing), 32'd0);
    endtask

    task automatic frame_start();
        bus.vsync = 1'b0;
        repeat (4) tick();
        bus.vsync = 1'b1;
    endtask

    // One line of p dots beginning with a one-dot hsync low. Outputs lag the
    // loop by two iterations, so index ci observes dot ci-2 (x = ci-3).
    task automatic line(input int p, input int ci, input logic ew,
                        input logic [31:0] ea, input string tag);
        for (int i = 0; i < p; i++) begin
            bus.hsync = (i == 0) ? 1'b0 : 1'b1;
            bus.video = i[0];
            tick();
            if (i == ci) begin
                check({tag, "_wren"}, 32'(bus.wren), 32'(ew));
                if (ew) begin
                    check({tag, "_waddr"}, 32'(bus.waddr), ea);
                    check({tag, "_pixel"}, 32'(bus.pixel_state), 32'((ci - 2) & 1));
                end
            end
        end
        bus.hsync = 1'b1;
    endtask

    // Trailing hsync fall that terminates the last line; returns after the
    // tick on which the line end takes effect.
    task automatic final_fall(input string tag);
        bus.hsync = 1'b0;
        tick();
        bus.hsync = 1'b1;
        tick();
        check({tag, "_mode_before"}, 32'(bus.mode), 32'd0);
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.video = 1'b0;
        repeat (3) tick();
        check("rst_waddr", 32'(bus.waddr), 32'd0);
        check("rst_wren", 32'(bus.wren), 32'd0);
        check("rst_pixel", 32'(bus.pixel_state), 32'd0);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_clearing", 32'(bus.clearing), 32'd1);
        reset = 1'b0;
        clear_check("boot_clear");

        // 64-col capture: row 0 x 0 -> 16, row 1 x 5 -> 821.
        frame_start();
        bus.video = 1'b1;
        repeat (3) tick();
        check("r0x0_wren", 32'(bus.wren), 32'd1);
        check("r0x0_waddr", 32'(bus.waddr), 32'd16);
        check("r0x0_pixel", 32'(bus.pixel_state), 32'd1);
        bus.video = 1'b0;
        repeat (636) tick();
        line(640, 8, 1'b1, 32'd821, "r1x5");
        line(640, 2, 1'b0, 32'd0, "r2_lineend");
        check("m0_mode", 32'(bus.mode), 32'd0);

        // Three long lines then a short one: filter resets, no switch.
        repeat (3) line(800, -1, 1'b0, 32'd0, "ns");
        line(640, -1, 1'b0, 32'd0, "ns");
        line(640, -1, 1'b0, 32'd0, "ns");
        check("ns_mode", 32'(bus.mode), 32'd0);
        check("ns_clearing", 32'(bus.clearing), 32'd0);

        // Glitch line between long lines is ignored; switch on 4th valid line.
        line(800, -1, 1'b0, 32'd0, "gl");
        line(800, -1, 1'b0, 32'd0, "gl");
        line(100, -1, 1'b0, 32'd0, "gl");
        line(800, -1, 1'b0, 32'd0, "gl");
        line(800, -1, 1'b0, 32'd0, "gl");
        check("gl_mode_pre", 32'(bus.mode), 32'd0);
        final_fall("gl");
        check("gl_mode", 32'(bus.mode), 32'd1);
        check("gl_clearing", 32'(bus.clearing), 32'd1);
        check("gl_wren", 32'(bus.wren), 32'd0);

        // Reset partway through the clear restarts it from address 0.
        repeat (1000) tick();
        check("mid_waddr", 32'(bus.waddr), 32'd999);
        check("mid_wren", 32'(bus.wren), 32'd1);
        reset = 1'b1;
        tick();
        check("rr_waddr", 32'(bus.waddr), 32'd0);
        check("rr_wren", 32'(bus.wren), 32'd0);
        check("rr_mode", 32'(bus.mode), 32'd0);
        check("rr_clearing", 32'(bus.clearing), 32'd1);
        reset = 1'b0;
        clear_check("reset_clear");

        // Four consecutive 800-dot lines switch to 80-col.
        frame_start();
        repeat (799) tick();
        repeat (3) line(800, -1, 1'b0, 32'd0, "sw");
        final_fall("sw");
        check("sw_mode", 32'(bus.mode), 32'd1);
        check("sw_clearing", 32'(bus.clearing), 32'd1);
        clear_check("m1_clear");

        // 80-col placement: rows above Y_OFF1 are off-buffer, (8,71) -> 0.
        frame_start();
        repeat (3) tick();
        check("m1r0_wren", 32'(bus.wren), 32'd0);
        check("m1r0_waddr_hold", 32'(bus.waddr), 32'(DEPTH - 1));
        repeat (796) tick();
        repeat (6) line(800, -1, 1'b0, 32'd0, "m1");
        line(800, 500, 1'b0, 32'd0, "m1r7");
        line(800, 74, 1'b1, 32'd0, "m1r8x71");
        check("m1_mode_end", 32'(bus.mode), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
